// File: rtl/shift_pkg.sv
// Shared types for the universal shift register.
//   op_e        : 3-bit operation code driven on the op port
//   state_e     : burst controller state
//   is_shift_op : true for ops that move bits (SHL..ASR), i.e. the burstable ops
package shift_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5,
    ASR  = 3'd6,
    CLR  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic is_shift_op(input op_e o);
    return (o == SHL) || (o == SHR) || (o == ROL) || (o == ROR) || (o == ASR);
  endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational next-value logic for the universal shift register.
// Ports:
//   sr       : current register contents
//   op       : operation to apply
//   ser_in   : serial fill bits (used by SHL/SHR only)
//   par_in   : parallel load data
//   next_sr  : register value after applying op
//   out_bits : bits leaving the register for shift/rotate/ASR ops, else zero
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] sr,
  input  op_e              op,
  input  logic [STEP-1:0]  ser_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] next_sr,
  output logic [STEP-1:0]  out_bits
);

  always_comb begin
    next_sr  = sr;
    out_bits = '0;
    case (op)
      HOLD: next_sr = sr;
      LOAD: next_sr = par_in;
      SHL: begin
        next_sr  = {sr[WIDTH-STEP-1:0], ser_in};
        out_bits = sr[WIDTH-1 -: STEP];
      end
      SHR: begin
        next_sr  = {ser_in, sr[WIDTH-1:STEP]};
        out_bits = sr[STEP-1:0];
      end
      ROL: begin
        next_sr  = {sr[WIDTH-STEP-1:0], sr[WIDTH-1 -: STEP]};
        out_bits = sr[WIDTH-1 -: STEP];
      end
      ROR: begin
        next_sr  = {sr[STEP-1:0], sr[WIDTH-1:STEP]};
        out_bits = sr[STEP-1:0];
      end
      ASR: begin
        next_sr  = {{STEP{sr[WIDTH-1]}}, sr[WIDTH-1:STEP]};
        out_bits = sr[STEP-1:0];
      end
      CLR:     next_sr = '0;
      default: next_sr = sr;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, shift/rotate/arithmetic shift,
// a registered serial output and an auto-repeating burst mode.
// Ports:
//   Clk, Rst : clock and synchronous active-high reset
//   op       : operation code (shift_pkg::op_e encoding)
//   start    : request a burst of the shift op on op, count taken from count
//   count    : burst length, sampled when a burst start is accepted
//   par_in   : parallel load data
//   ser_in   : serial fill bits for SHL/SHR, sampled at every shift edge
//   Out      : register contents
//   ser_out  : bits shifted out by the most recent shift/rotate/ASR
//   busy     : high while a burst is running
//   done     : one-cycle pulse in the cycle after a burst's last shift
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] par_in,
  input  logic [STEP-1:0]  ser_in,
  output logic [WIDTH-1:0] Out,
  output logic [STEP-1:0]  ser_out,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2 || STEP < 1 || STEP >= WIDTH) begin : g_bad_params
    $error("univ_shift_reg: need WIDTH >= 2 and 1 <= STEP < WIDTH");
  end

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt_rem, cnt_nxt;
  op_e              op_lat, op_lat_nxt;
  op_e              apply_op;
  logic             do_upd;
  logic             done_nxt;
  logic [WIDTH-1:0] sr, next_sr;
  logic [STEP-1:0]  out_bits;

  shift_unit #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_shift (
    .sr      (sr),
    .op      (apply_op),
    .ser_in  (ser_in),
    .par_in  (par_in),
    .next_sr (next_sr),
    .out_bits(out_bits)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_rem;
    op_lat_nxt = op_lat;
    apply_op   = op_e'(op);
    do_upd     = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start && is_shift_op(op_e'(op))) begin
          // Acceptance edge: latch the burst, no shift yet. A zero-length
          // burst completes immediately without touching the register.
          op_lat_nxt = op_e'(op);
          if (count != '0) begin
            state_nxt = RUN;
            cnt_nxt   = count;
          end else begin
            done_nxt = 1'b1;
          end
        end else begin
          do_upd = 1'b1;
        end
      end
      RUN: begin
        apply_op = op_lat;
        do_upd   = 1'b1;
        if (cnt_rem == CNT_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_rem - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      cnt_rem <= '0;
      op_lat  <= HOLD;
      done    <= 1'b0;
      sr      <= '0;
      ser_out <= '0;
    end else begin
      state   <= state_nxt;
      cnt_rem <= cnt_nxt;
      op_lat  <= op_lat_nxt;
      done    <= done_nxt;
      if (do_upd) begin
        sr <= next_sr;
        // HOLD/LOAD/CLR keep the last shifted-out bits visible.
        if (is_shift_op(apply_op)) ser_out <= out_bits;
      end
    end
  end

  assign Out  = sr;
  assign busy = (state == RUN);

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  logic       Clk = 1'b0;
  logic       Rst;
  // STEP=1 instance
  logic [2:0] op;
  logic       start;
  logic [7:0] count;
  logic [7:0] par_in;
  logic [0:0] ser_in;
  logic [7:0] Out;
  logic [0:0] ser_out;
  logic       busy, done;
  // STEP=4 instance
  logic [2:0] op4;
  logic       start4;
  logic [7:0] count4;
  logic [7:0] par_in4;
  logic [3:0] ser_in4;
  logic [7:0] Out4;
  logic [3:0] ser_out4;
  logic       busy4, done4;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR = 3'd7;

  always #5 Clk = ~Clk;

  univ_shift_reg #(.WIDTH(8), .STEP(1), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .op(op), .start(start), .count(count),
    .par_in(par_in), .ser_in(ser_in), .Out(Out), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  univ_shift_reg #(.WIDTH(8), .STEP(4), .CNT_W(8)) dut4 (
    .Clk(Clk), .Rst(Rst), .op(op4), .start(start4), .count(count4),
    .par_in(par_in4), .ser_in(ser_in4), .Out(Out4), .ser_out(ser_out4),
    .busy(busy4), .done(done4)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] par;
    logic       ser;
    logic [7:0] eout;
    logic       eser;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{LOAD, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vt[1]  = '{SHL,  8'h00, 1'b1, 8'h4B, 1'b1};
    vt[2]  = '{LOAD, 8'h81, 1'b0, 8'h81, 1'b1};
    vt[3]  = '{ROR,  8'h00, 1'b0, 8'hC0, 1'b1};
    vt[4]  = '{LOAD, 8'h80, 1'b0, 8'h80, 1'b1};
    vt[5]  = '{ASR,  8'h00, 1'b1, 8'hC0, 1'b0};
    vt[6]  = '{LOAD, 8'h80, 1'b0, 8'h80, 1'b0};
    vt[7]  = '{SHR,  8'h00, 1'b0, 8'h40, 1'b0};
    vt[8]  = '{ROL,  8'h00, 1'b1, 8'h80, 1'b0};
    vt[9]  = '{HOLD, 8'h00, 1'b0, 8'h80, 1'b0};
    vt[10] = '{ROL,  8'h00, 1'b0, 8'h01, 1'b1};
    vt[11] = '{CLR,  8'h00, 1'b0, 8'h00, 1'b1};

    // Reset with a LOAD pending: reset must win.
    Rst = 1'b1; op = LOAD; par_in = 8'hFF; start = 1'b0; count = 8'd0; ser_in = 1'b0;
    op4 = LOAD; par_in4 = 8'hFF; start4 = 1'b0; count4 = 8'd0; ser_in4 = 4'h0;
    tick(); tick();
    chk("rst_out", Out, 8'h00);
    chk("rst_ser", ser_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out4", Out4, 8'h00);
    Rst = 1'b0; op4 = HOLD;

    // Single-step table
    for (int i = 0; i < 12; i++) begin
      op = vt[i].op; par_in = vt[i].par; ser_in = vt[i].ser;
      tick();
      chk($sformatf("vec%0d_out", i), Out, vt[i].eout);
      chk($sformatf("vec%0d_ser", i), ser_out, vt[i].eser);
      chk($sformatf("vec%0d_busy", i), busy, 1'b0);
    end

    // Burst: ROL x3 from 01, op toggled during the burst
    op = LOAD; par_in = 8'h01; tick();
    op = ROL; start = 1'b1; count = 8'd3; tick();
    chk("b_acc_out", Out, 8'h01);
    chk("b_acc_busy", busy, 1'b1);
    op = CLR; start = 1'b0; count = 8'd0; par_in = 8'hEE; tick();
    chk("b1_out", Out, 8'h02); chk("b1_busy", busy, 1'b1); chk("b1_done", done, 1'b0);
    tick();
    chk("b2_out", Out, 8'h04); chk("b2_busy", busy, 1'b1);
    op = HOLD; tick();
    chk("b3_out", Out, 8'h08); chk("b3_busy", busy, 1'b0); chk("b3_done", done, 1'b1);
    chk("b3_ser", ser_out, 1'b0);
    tick();
    chk("b_after_out", Out, 8'h08); chk("b_after_done", done, 1'b0);

    // Back-to-back single-shift bursts: accept a new start in the done cycle
    op = SHR; ser_in = 1'b1; start = 1'b1; count = 8'd1; tick();
    chk("bb_acc_busy", busy, 1'b1); chk("bb_acc_out", Out, 8'h08);
    tick();
    chk("bb1_out", Out, 8'h84); chk("bb1_done", done, 1'b1); chk("bb1_busy", busy, 1'b0);
    ser_in = 1'b0; tick();
    chk("bb2_acc_busy", busy, 1'b1); chk("bb2_acc_done", done, 1'b0);
    start = 1'b0; op = HOLD; tick();
    chk("bb2_out", Out, 8'h42); chk("bb2_done", done, 1'b1);

    // Zero-count burst
    op = LOAD; par_in = 8'h3C; tick();
    op = SHL; ser_in = 1'b1; start = 1'b1; count = 8'd0; tick();
    chk("z_done", done, 1'b1); chk("z_busy", busy, 1'b0); chk("z_out", Out, 8'h3C);
    op = HOLD; start = 1'b0; tick();
    chk("z_done2", done, 1'b0); chk("z_busy2", busy, 1'b0); chk("z_out2", Out, 8'h3C);

    // Abort: reset after 2 of 5 shifts
    op = LOAD; par_in = 8'h01; tick();
    op = SHL; ser_in = 1'b0; start = 1'b1; count = 8'd5; tick();
    start = 1'b0; op = HOLD; tick();
    chk("a1_out", Out, 8'h02);
    tick();
    chk("a2_out", Out, 8'h04); chk("a2_busy", busy, 1'b1);
    Rst = 1'b1; tick();
    chk("a_rst_out", Out, 8'h00); chk("a_rst_busy", busy, 1'b0); chk("a_rst_done", done, 1'b0);
    Rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("a_post%0d_done", i), done, 1'b0);
      chk($sformatf("a_post%0d_busy", i), busy, 1'b0);
      chk($sformatf("a_post%0d_out", i), Out, 8'h00);
    end

    // STEP=4 variant
    op4 = LOAD; par_in4 = 8'h12; tick();
    chk("s4_load", Out4, 8'h12);
    op4 = SHL; ser_in4 = 4'hF; tick();
    chk("s4_shl_out", Out4, 8'h2F); chk("s4_shl_ser", ser_out4, 4'h1);
    op4 = ROR; ser_in4 = 4'h0; tick();
    chk("s4_ror_out", Out4, 8'hF2); chk("s4_ror_ser", ser_out4, 4'hF);
    op4 = ASR; tick();
    chk("s4_asr_out", Out4, 8'hFF); chk("s4_asr_ser", ser_out4, 4'h2);
    op4 = HOLD; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
